// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The optional performance counters in hazard_ctrl are built only when HAZARD_PERF_EN is defined.
package hazard_pkg;

   typedef enum logic [1:0] {
      INIT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } hazard_state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [1:0] LOAD_SRC_DEFAULT = 2'b01;

endpackage

// File: rtl/hazard_forward_unit.sv
// Operand forwarding select for one EX source operand.
// The MEM stage result wins over the WB result, and x0 is never forwarded.
module forward_unit
   import hazard_pkg::*;
(
   input  logic [4:0] rs_ex_i,
   input  logic [4:0] write_address_mem_i,
   input  logic       reg_write_mem_i,
   input  logic [4:0] write_address_wb_i,
   input  logic       reg_write_wb_i,
   output logic [1:0] fwd_sel_o
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = reg_write_mem_i && (write_address_mem_i != 5'd0) && (write_address_mem_i == rs_ex_i);
   assign wb_hit  = reg_write_wb_i  && (write_address_wb_i  != 5'd0) && (write_address_wb_i  == rs_ex_i);

   always_comb begin
      fwd_sel_o = FWD_RF;
      if (mem_hit) begin
         fwd_sel_o = FWD_MEM;
      end else if (wb_hit) begin
         fwd_sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: post-reset pipeline clear, memory-wait freeze,
// branch flush, load-use stall and EX forwarding. Define HAZARD_PERF_EN to build the stall/flush counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned INIT_CYCLES = 4,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter logic [1:0]  LOAD_SRC    = LOAD_SRC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  rs1Addr_ID,
   input  logic [4:0]  rs2Addr_ID,
   input  logic [4:0]  rs1Addr_EX,
   input  logic [4:0]  rs2Addr_EX,
   input  logic [4:0]  writeAddress_EX,
   input  logic [1:0]  resultSrc_EX,
   input  logic        regWrite_EX,
   input  logic [4:0]  writeAddress_MEM,
   input  logic        regWrite_MEM,
   input  logic [4:0]  writeAddress_WB,
   input  logic        regWrite_WB,
   input  logic        pcSrc_EX,
   input  logic        memReq_MEM,
   input  logic        memReady_MEM,
   output logic [1:0]  forwardA_EX,
   output logic [1:0]  forwardB_EX,
   output logic        stall_IF,
   output logic        stall_ID,
   output logic        stall_EX,
   output logic        stall_MEM,
   output logic        flush_ID,
   output logic        flush_EX,
   output logic        bubble_WB,
   output logic        memTimeout,
   output logic [31:0] stallCount,
   output logic [31:0] flushCount
);

   localparam logic [3:0]  INIT_LAST = 4'(INIT_CYCLES - 1);
   localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

   hazard_state_e state_q, state_d;
   logic [3:0]    init_cnt_q, init_cnt_d;
   logic [15:0]   wait_cnt_q, wait_cnt_d;

   logic [1:0] fwd_a, fwd_b;
   logic       mem_miss;
   logic       load_use;

   forward_unit u_fwd_a (
      .rs_ex_i             (rs1Addr_EX),
      .write_address_mem_i (writeAddress_MEM),
      .reg_write_mem_i     (regWrite_MEM),
      .write_address_wb_i  (writeAddress_WB),
      .reg_write_wb_i      (regWrite_WB),
      .fwd_sel_o           (fwd_a)
   );

   forward_unit u_fwd_b (
      .rs_ex_i             (rs2Addr_EX),
      .write_address_mem_i (writeAddress_MEM),
      .reg_write_mem_i     (regWrite_MEM),
      .write_address_wb_i  (writeAddress_WB),
      .reg_write_wb_i      (regWrite_WB),
      .fwd_sel_o           (fwd_b)
   );

   assign mem_miss = memReq_MEM && !memReady_MEM;
   assign load_use = (resultSrc_EX == LOAD_SRC) && regWrite_EX && (writeAddress_EX != 5'd0) &&
                     ((writeAddress_EX == rs1Addr_ID) || (writeAddress_EX == rs2Addr_ID));

   // The pipeline registers themselves carry no reset; the INIT flush is what clears them.
   assign forwardA_EX = (state_q == INIT) ? FWD_RF : fwd_a;
   assign forwardB_EX = (state_q == INIT) ? FWD_RF : fwd_b;

   always_comb begin
      // NOTE: every output and next-state value gets a default first so no path infers a latch.
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      wait_cnt_d = wait_cnt_q;
      stall_IF   = 1'b0;
      stall_ID   = 1'b0;
      stall_EX   = 1'b0;
      stall_MEM  = 1'b0;
      flush_ID   = 1'b0;
      flush_EX   = 1'b0;
      bubble_WB  = 1'b0;
      memTimeout = 1'b0;

      case (state_q)
         INIT: begin
            stall_IF  = 1'b1;
            flush_ID  = 1'b1;
            flush_EX  = 1'b1;
            bubble_WB = 1'b1;
            if (init_cnt_q == INIT_LAST) begin
               state_d    = RUN;
               init_cnt_d = 4'd0;
            end else begin
               init_cnt_d = init_cnt_q + 4'd1;
            end
         end

         RUN: begin
            if (mem_miss) begin
               {stall_IF, stall_ID, stall_EX, stall_MEM, bubble_WB} = 5'b11111;
               state_d    = MEM_WAIT;
               wait_cnt_d = 16'd1;
            end else if (pcSrc_EX) begin
               flush_ID = 1'b1;
               flush_EX = 1'b1;
            end else if (load_use) begin
               stall_IF = 1'b1;
               stall_ID = 1'b1;
               flush_EX = 1'b1;
            end
         end

         MEM_WAIT: begin
            // The releasing cycle still holds the pipeline; the stalls are gone from the next cycle.
            {stall_IF, stall_ID, stall_EX, stall_MEM, bubble_WB} = 5'b11111;
            if (memReady_MEM) begin
               state_d    = RUN;
               wait_cnt_d = 16'd0;
            end else if (wait_cnt_q == WAIT_LAST) begin
               memTimeout = 1'b1;
               state_d    = RUN;
               wait_cnt_d = 16'd0;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end

         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         init_cnt_q <= 4'd0;
         wait_cnt_q <= 16'd0;
      end else begin
         // NOTE: sequential state is updated only with non-blocking assignments.
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else if (state_q != INIT) begin
         if (stall_IF) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (flush_EX) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stallCount = stall_cnt_q;
   assign flushCount = flush_cnt_q;
`else
   assign stallCount = 32'd0;
   assign flushCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic, all compared
// cycle by cycle against a behavioural model built from the controller's rules.
module tb_hazard_ctrl;

   localparam int unsigned INIT_CYCLES = 4;
   localparam int unsigned MEM_TIMEOUT = 8;
   localparam logic [1:0]  LOAD_SRC    = 2'b01;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs1Addr_ID, rs2Addr_ID, rs1Addr_EX, rs2Addr_EX;
   logic [4:0]  writeAddress_EX, writeAddress_MEM, writeAddress_WB;
   logic [1:0]  resultSrc_EX;
   logic        regWrite_EX, regWrite_MEM, regWrite_WB;
   logic        pcSrc_EX, memReq_MEM, memReady_MEM;
   logic [1:0]  forwardA_EX, forwardB_EX;
   logic        stall_IF, stall_ID, stall_EX, stall_MEM;
   logic        flush_ID, flush_EX, bubble_WB, memTimeout;
   logic [31:0] stallCount, flushCount;

   hazard_ctrl #(
      .INIT_CYCLES (INIT_CYCLES),
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .LOAD_SRC    (LOAD_SRC)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .rs1Addr_ID       (rs1Addr_ID),
      .rs2Addr_ID       (rs2Addr_ID),
      .rs1Addr_EX       (rs1Addr_EX),
      .rs2Addr_EX       (rs2Addr_EX),
      .writeAddress_EX  (writeAddress_EX),
      .resultSrc_EX     (resultSrc_EX),
      .regWrite_EX      (regWrite_EX),
      .writeAddress_MEM (writeAddress_MEM),
      .regWrite_MEM     (regWrite_MEM),
      .writeAddress_WB  (writeAddress_WB),
      .regWrite_WB      (regWrite_WB),
      .pcSrc_EX         (pcSrc_EX),
      .memReq_MEM       (memReq_MEM),
      .memReady_MEM     (memReady_MEM),
      .forwardA_EX      (forwardA_EX),
      .forwardB_EX      (forwardB_EX),
      .stall_IF         (stall_IF),
      .stall_ID         (stall_ID),
      .stall_EX         (stall_EX),
      .stall_MEM        (stall_MEM),
      .flush_ID         (flush_ID),
      .flush_EX         (flush_EX),
      .bubble_WB        (bubble_WB),
      .memTimeout       (memTimeout),
      .stallCount       (stallCount),
      .flushCount       (flushCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] fa;
      logic [1:0] fb;
      logic s_if, s_id, s_ex, s_mem, f_id, f_ex, b_wb, mto;
   } outs_t;

   localparam outs_t INIT_OUTS = '{fa: 2'b00, fb: 2'b00, s_if: 1'b1, s_id: 1'b0, s_ex: 1'b0,
                                   s_mem: 1'b0, f_id: 1'b1, f_ex: 1'b1, b_wb: 1'b1, mto: 1'b0};

   int n_cmp = 0;
   int n_bad = 0;

   // Model: cycles of clearing still owed, and age of an outstanding miss (0 = none).
   int          init_left;
   int          wait_age;
   logic [31:0] m_stall_cnt;
   logic [31:0] m_flush_cnt;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
      if (regWrite_MEM && writeAddress_MEM != 0 && writeAddress_MEM == rs) return 2'b10;
      if (regWrite_WB && writeAddress_WB != 0 && writeAddress_WB == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic outs_t model_outs();
      outs_t o;
      logic  lu;
      o = '0;
      if (init_left > 0) return INIT_OUTS;
      o.fa = fwd_ref(rs1Addr_EX);
      o.fb = fwd_ref(rs2Addr_EX);
      lu = (resultSrc_EX == LOAD_SRC) && regWrite_EX && writeAddress_EX != 0 &&
           (writeAddress_EX == rs1Addr_ID || writeAddress_EX == rs2Addr_ID);
      if (wait_age > 0) begin
         {o.s_if, o.s_id, o.s_ex, o.s_mem, o.b_wb} = 5'b11111;
         o.mto = !memReady_MEM && (wait_age == int'(MEM_TIMEOUT) - 1);
      end else if (memReq_MEM && !memReady_MEM) begin
         {o.s_if, o.s_id, o.s_ex, o.s_mem, o.b_wb} = 5'b11111;
      end else if (pcSrc_EX) begin
         o.f_id = 1'b1;
         o.f_ex = 1'b1;
      end else if (lu) begin
         o.s_if = 1'b1;
         o.s_id = 1'b1;
         o.f_ex = 1'b1;
      end
      return o;
   endfunction

   function automatic outs_t dut_outs();
      return {forwardA_EX, forwardB_EX, stall_IF, stall_ID, stall_EX, stall_MEM,
              flush_ID, flush_EX, bubble_WB, memTimeout};
   endfunction

   task automatic model_reset();
      init_left   = INIT_CYCLES;
      wait_age    = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
   endtask

   task automatic check_counters(input string tag);
`ifdef HAZARD_PERF_EN
      check({tag, "_stall_cnt"}, stallCount, m_stall_cnt);
      check({tag, "_flush_cnt"}, flushCount, m_flush_cnt);
`else
      check({tag, "_stall_cnt_tied"}, stallCount, 32'd0);
      check({tag, "_flush_cnt_tied"}, flushCount, 32'd0);
`endif
   endtask

   // One clock cycle: compare at the falling edge, advance the model on the rising edge.
   task automatic step(input string tag);
      outs_t e;
      if (clk !== 1'b0) @(negedge clk);
      e = model_outs();
      check(tag, 32'(dut_outs()), 32'(e));
      check_counters(tag);
      @(posedge clk);
      if (init_left > 0) begin
         init_left--;
      end else begin
         if (e.s_if) m_stall_cnt++;
         if (e.f_ex) m_flush_cnt++;
         if (wait_age > 0) begin
            if (memReady_MEM || wait_age == int'(MEM_TIMEOUT) - 1) wait_age = 0;
            else wait_age++;
         end else if (memReq_MEM && !memReady_MEM) begin
            wait_age = 1;
         end
      end
      #1;
   endtask

   task automatic clear_inputs();
      {rs1Addr_ID, rs2Addr_ID, rs1Addr_EX, rs2Addr_EX} = '0;
      {writeAddress_EX, writeAddress_MEM, writeAddress_WB} = '0;
      resultSrc_EX = 2'b00;
      {regWrite_EX, regWrite_MEM, regWrite_WB} = '0;
      {pcSrc_EX, memReq_MEM, memReady_MEM} = '0;
   endtask

   task automatic random_inputs();
      rs1Addr_ID       = 5'($urandom_range(0, 3));
      rs2Addr_ID       = 5'($urandom_range(0, 3));
      rs1Addr_EX       = 5'($urandom_range(0, 3));
      rs2Addr_EX       = 5'($urandom_range(0, 3));
      writeAddress_EX  = 5'($urandom_range(0, 3));
      writeAddress_MEM = 5'($urandom_range(0, 3));
      writeAddress_WB  = 5'($urandom_range(0, 3));
      resultSrc_EX     = 2'($urandom_range(0, 3));
      regWrite_EX      = 1'($urandom);
      regWrite_MEM     = 1'($urandom);
      regWrite_WB      = 1'($urandom);
      pcSrc_EX         = ($urandom_range(0, 4) == 0);
      memReq_MEM       = ($urandom_range(0, 5) == 0) || (wait_age > 0);
      memReady_MEM     = ($urandom_range(0, 3) == 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] stall_before;

      // Reset held: INIT outputs, counters clear.
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      @(negedge clk);
      check("rst_held", 32'(dut_outs()), 32'(INIT_OUTS));
      check_counters("rst_held");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Post-reset clear lasts exactly INIT_CYCLES cycles.
      @(negedge clk);
      check("init_first", {stall_IF, flush_ID, flush_EX, bubble_WB}, 4'hF);
      for (int i = 0; i < int'(INIT_CYCLES); i++) step("init");
      @(negedge clk);
      check("run_entry", {stall_IF, flush_ID, flush_EX, bubble_WB}, 4'h0);
      step("run_entry");

      // Forwarding priority and x0.
      regWrite_MEM = 1'b1; writeAddress_MEM = 5'd5;
      regWrite_WB  = 1'b1; writeAddress_WB  = 5'd5;
      rs1Addr_EX   = 5'd5;
      @(negedge clk);
      check("fwd_mem", forwardA_EX, 2'b10);
      step("fwd_mem");
      regWrite_MEM = 1'b0;
      @(negedge clk);
      check("fwd_wb", forwardA_EX, 2'b01);
      step("fwd_wb");
      regWrite_MEM = 1'b1; writeAddress_MEM = 5'd0; writeAddress_WB = 5'd0; rs1Addr_EX = 5'd0;
      @(negedge clk);
      check("fwd_x0", forwardA_EX, 2'b00);
      step("fwd_x0");
      clear_inputs();

      // Load-use: one bubble, then clean once the load has moved on.
      resultSrc_EX = LOAD_SRC; regWrite_EX = 1'b1; writeAddress_EX = 5'd7; rs2Addr_ID = 5'd7;
      @(negedge clk);
      check("load_use", {stall_IF, stall_ID, flush_EX, flush_ID, stall_EX}, 5'b11100);
      step("load_use");
      regWrite_EX = 1'b0;
      @(negedge clk);
      check("load_use_clear", 32'(dut_outs()), 32'd0);
      step("load_use_clear");

      // Branch wins over load-use.
      regWrite_EX = 1'b1; pcSrc_EX = 1'b1;
      @(negedge clk);
      check("branch_vs_lu", {flush_ID, flush_EX, stall_IF}, 3'b110);
      step("branch_vs_lu");
      clear_inputs();

      // Miss with ready after 3 cycles: 4 frozen cycles, no timeout.
      memReq_MEM = 1'b1;
      for (int i = 0; i < 4; i++) begin
         memReady_MEM = (i == 3);
         @(negedge clk);
         check("miss_hold", {stall_IF, stall_ID, stall_EX, stall_MEM, bubble_WB, memTimeout}, 6'b111110);
         step("miss_hold");
      end
      clear_inputs();
      @(negedge clk);
      check("miss_release", {stall_IF, stall_ID, stall_EX, stall_MEM, bubble_WB}, 5'b00000);
      step("miss_release");

      // Memory never ready: 8 frozen cycles, timeout pulse in the last.
      memReq_MEM   = 1'b1;
      stall_before = stallCount;
      for (int i = 0; i < int'(MEM_TIMEOUT); i++) begin
         @(negedge clk);
         check("timeout_hold", {stall_IF, stall_MEM, bubble_WB, memTimeout}, {3'b111, (i == int'(MEM_TIMEOUT) - 1)});
         step("timeout_hold");
      end
      memReq_MEM = 1'b0;
      @(negedge clk);
      check("timeout_release", {stall_IF, memTimeout}, 2'b00);
`ifdef HAZARD_PERF_EN
      check("timeout_stall_cnt", stallCount - stall_before, 32'd8);
`endif
      step("timeout_release");

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         random_inputs();
         step("random");
      end
      clear_inputs();
      while (wait_age > 0) begin
         memReady_MEM = 1'b1;
         memReq_MEM   = 1'b1;
         step("drain");
      end
      clear_inputs();

      // Reset mid MEM_WAIT: immediate INIT outputs, then a full replay.
      memReq_MEM = 1'b1; regWrite_MEM = 1'b1; writeAddress_MEM = 5'd3; rs1Addr_EX = 5'd3;
      step("pre_reset_miss");
      step("pre_reset_wait");
      rst_n = 1'b0;
      #1;
      check("async_rst", 32'(dut_outs()), 32'(INIT_OUTS));
      model_reset();
      check_counters("async_rst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      clear_inputs();
      for (int i = 0; i < int'(INIT_CYCLES); i++) step("replay_init");
      for (int i = 0; i < 20; i++) begin
         random_inputs();
         step("replay_run");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
